twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/ntt_pkg.sv | 21 ++
 rtl/barrett_mul.sv | 73 +++++++
 rtl/twiddle_gen.sv | 116 +++++++++++
 tb/tb_twiddle_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and default constants for the NTT twiddle-factor datapath.
package ntt_pkg;

  // Default coefficient width and Barrett constant for modulus q = 201:
  // floor(2^(2*8+1) / 201) = 652.
  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_PRE_WIDTH = 10;
  localparam logic [DEF_PRE_WIDTH-1:0] DEF_PRECOMPUTE = 10'd652;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    MUL  = 2'd2
  } state_t;

  // Barrett shift matching the precompute constant: floor(2^(2*D+1) / q).
  function automatic int barrett_shift(input int d_width);
    return 2 * d_width + 1;
  endfunction

endpackage

// File: rtl/barrett_mul.sv
// Pipelined modular multiplier: result = (a * b) mod modulus after MUL_LAT
// clocks. The full 2*D_WIDTH product is registered first, then reduced with a
// Barrett estimate plus correction; remaining latency is a register chain.
// PRECOMPUTE must correspond to the modulus in use.
module barrett_mul
  import ntt_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH,
  parameter logic [PRE_WIDTH-1:0] PRECOMPUTE = DEF_PRECOMPUTE,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic [D_WIDTH-1:0] modulus,
  output logic [D_WIDTH-1:0] result
);

  localparam int PW = 2 * D_WIDTH;
  localparam int XW = PW + PRE_WIDTH;
  localparam int SHIFT = barrett_shift(D_WIDTH);

  // Quotient estimate undershoots by at most one, so r < 2q before the
  // corrections; the second subtraction is a cheap guard.
  function automatic logic [D_WIDTH-1:0] reduce(input logic [PW-1:0] x,
                                                input logic [D_WIDTH-1:0] q);
    logic [XW-1:0] qx;
    logic [XW-1:0] qhat;
    logic [XW-1:0] r;
    qx = XW'(q);
    qhat = (XW'(x) * XW'(PRECOMPUTE)) >> SHIFT;
    r = XW'(x) - qhat * qx;
    if (r >= qx) r = r - qx;
    if (r >= qx) r = r - qx;
    return D_WIDTH'(r);
  endfunction

  logic [PW-1:0]      prod_p0;
  logic [D_WIDTH-1:0] red_p0;

  // ---- stage p0: full-width product, no truncation ----
  // Register the raw product of the operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prod_p0 <= '0;
    else      prod_p0 <= PW'(a) * PW'(b);
  end

  assign red_p0 = reduce(prod_p0, modulus);

  generate
    if (MUL_LAT <= 1) begin : g_lat1
      assign result = red_p0;
    end else begin : g_latn
      logic [D_WIDTH-1:0] res_pn [1:MUL_LAT-1];

      // ---- stages p1..pN: reduced result delay chain ----
      // Shift the reduced value through the remaining latency registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 1; i < MUL_LAT; i++) res_pn[i] <= '0;
        end else begin
          res_pn[1] <= red_p0;
          for (int i = 2; i < MUL_LAT; i++) res_pn[i] <= res_pn[i-1];
        end
      end

      assign result = res_pn[MUL_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator: emits w^0 .. w^(N-1) mod q over a valid/ready
// stream, one modular multiply between consecutive outputs.
module twiddle_gen
  import ntt_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH,
  parameter logic [PRE_WIDTH-1:0] PRECOMPUTE = DEF_PRECOMPUTE,
  parameter int CNT_WIDTH = 12,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [D_WIDTH-1:0]   base,
  input  logic [CNT_WIDTH-1:0] length,
  input  logic [D_WIDTH-1:0]   modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [D_WIDTH-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MUL_LAT - 1);

  state_t               state;
  state_t               state_nx;
  logic [D_WIDTH-1:0]   acc;
  logic [D_WIDTH-1:0]   w;
  logic [CNT_WIDTH-1:0] k;
  logic [CNT_WIDTH-1:0] n;
  logic [MC_W-1:0]      mul_cnt;
  logic [D_WIDTH-1:0]   product;
  logic                 is_last;
  logic                 launch;

  // k never exceeds n-1, so the compare cannot be fooled by wrap-around.
  assign is_last = (k == n - CNT_WIDTH'(1));
  assign launch  = start && (length != '0);

  barrett_mul #(
    .D_WIDTH   (D_WIDTH),
    .PRE_WIDTH (PRE_WIDTH),
    .PRECOMPUTE(PRECOMPUTE),
    .MUL_LAT   (MUL_LAT)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .a      (acc),
    .b      (w),
    .modulus(modulus),
    .result (product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (launch) state_nx = EMIT;
      EMIT: if (out_ready) state_nx = is_last ? IDLE : MUL;
      MUL:  if (mul_cnt == MC_LAST) state_nx = EMIT;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs; data is forced to zero outside EMIT so idle/reset reads clean.
  always_comb begin
    out_valid = (state == EMIT);
    out_data  = (state == EMIT) ? acc : '0;
    out_last  = (state == EMIT) && is_last;
    busy      = (state != IDLE);
  end

  // Sequence registers: latch request, step index, capture product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      w       <= '0;
      k       <= '0;
      n       <= '0;
      mul_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            w   <= base;
            n   <= length;
            k   <= '0;
            acc <= (modulus == D_WIDTH'(1)) ? '0 : D_WIDTH'(1);
          end
        end
        EMIT: begin
          // The multiplier samples acc*w on this same edge.
          if (out_ready && !is_last) begin
            k       <= k + CNT_WIDTH'(1);
            mul_cnt <= '0;
          end
        end
        MUL: begin
          mul_cnt <= mul_cnt + MC_W'(1);
          if (mul_cnt == MC_LAST) acc <= product;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Testbench for twiddle_gen: directed and randomized sequences checked
// against a modular-exponentiation reference model.
module tb_twiddle_gen;

  localparam int D_WIDTH = 8;
  localparam int CNT_WIDTH = 12;
  localparam int MUL_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [D_WIDTH-1:0]   base;
  logic [CNT_WIDTH-1:0] length;
  logic [D_WIDTH-1:0]   modulus;
  logic                 out_valid;
  logic                 out_ready;
  logic [D_WIDTH-1:0]   out_data;
  logic                 out_last;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  twiddle_gen #(
    .D_WIDTH   (D_WIDTH),
    .PRE_WIDTH (10),
    .PRECOMPUTE(10'd652),
    .CNT_WIDTH (CNT_WIDTH),
    .MUL_LAT   (MUL_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .length   (length),
    .modulus  (modulus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the sampling edge.
  task automatic launch(input int w, input int n);
    @(negedge clk);
    base = w[D_WIDTH-1:0];
    length = n[CNT_WIDTH-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles on the
  // 2nd output; 3: ready high and start pulsed whenever busy without valid.
  task automatic run(input string tag, input int w, input int n, input int mode, input int stop);
    int q, expv, got, cyc, first, last, stall;
    logic rdy;
    q = int'(modulus);
    expv = 1 % q;
    got = 0; cyc = 0; first = -1; last = 0; stall = 0;
    while (got < stop && cyc < n * 40 + 200) begin
      if (mode == 3) begin
        start = !out_valid && busy;
        base = 8'd7;
        length = 12'd2;
      end
      rdy = 1'b1;
      if (mode == 1) rdy = 1'($urandom_range(0, 1));
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        check({tag, "_data"}, 32'(out_data), 32'(expv));
        check({tag, "_last"}, 32'(out_last), 32'(got == n - 1));
        if (mode == 2 && got == 1 && stall < 5) begin
          rdy = 1'b0;
          stall++;
        end
      end
      out_ready = rdy;
      if (out_valid && rdy) begin
        got++;
        expv = (expv * w) % q;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(stop));
    if (mode == 2) check({tag, "_stall_cycles"}, 32'(stall), 32'd5);
    if (mode == 0 && got == n && n > 1)
      check({tag, "_rate"}, 32'(last - first), 32'((n - 1) * (MUL_LAT + 1)));
    if (stop == n) begin
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int t;
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    base = '0;
    length = '0;
    modulus = 8'd201;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Known sequence 1, 59, 64, 158 with first valid one cycle after start.
    launch(59, 4);
    check("w59_first_latency", 32'(out_valid), 32'd1);
    run("w59", 59, 4, 0, 4);

    // Back-pressure on the second output: 1, 66 (held), 135.
    launch(66, 3);
    run("stall", 66, 3, 2, 3);

    // Zero-length request is ignored.
    launch(5, 0);
    for (int i = 0; i < 3; i++) begin
      check("len0_valid", 32'(out_valid), 32'd0);
      check("len0_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Start pulses while multiplying must not disturb the sequence.
    launch(11, 5);
    run("start_in_mul", 11, 5, 3, 5);
    for (int i = 0; i < 4; i++) begin
      check("start_in_mul_quiet", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Reset mid-sequence, then a fresh run 1, 2, 4.
    launch(3, 8);
    run("pre_reset", 3, 8, 0, 2);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("reset_wait_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("reset_now_valid", 32'(out_valid), 32'd0);
    check("reset_now_busy", 32'(busy), 32'd0);
    check("reset_now_data", 32'(out_data), 32'd0);
    check("reset_now_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_quiet", 32'(out_valid), 32'd0);
    end
    launch(2, 3);
    run("after_reset", 2, 3, 0, 3);

    // Modulus one: every power reduces to zero.
    modulus = 8'd1;
    launch(0, 3);
    run("q1", 0, 3, 0, 3);
    modulus = 8'd201;

    // Randomized roots and lengths under random back-pressure.
    for (int i = 0; i < 6; i++) begin
      int w, n;
      w = int'($urandom_range(0, 200));
      n = int'($urandom_range(1, 64));
      launch(w, n);
      run("rand", w, n, 1, n);
    end

    // Maximum length: index counter must not wrap.
    begin
      int w;
      w = int'($urandom_range(2, 200));
      launch(w, 4095);
      run("full_len", w, 4095, 0, 4095);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
